nios_dbg_cmd_sysclk: RTL

- Next-generation system-clock side of the Nios II debug slave.
- Receives JTAG update events from the TCK domain as a toggle, plus a held IR/shift-register snapshot. Synchronises the toggle, buffers commands in a small FIFO and presents them with a valid/ready handshake.
- Decodes one-hot take_action / take_no_action strobes per IR code.
- Generalised over IR width, shift-register width, FIFO depth and synchroniser depth. The previous generation had a fixed 2-bit IR, a fixed 38-bit data path and no buffering.

---
 rtl/nios_dbg_pkg.sv | 24 ++
 rtl/nios_dbg_toggle_sync.sv | 27 ++
 rtl/nios_dbg_cmd_sysclk.sv | 129 ++++++++++++
 3 files changed

// File: rtl/nios_dbg_pkg.sv
// Shared constants and helpers for the Nios II debug slave, system-clock side.
package nios_dbg_pkg;

    localparam int IR_W_DEF = 2;
    localparam int SR_W_DEF = 38;

    // JTAG instruction codes seen by the debug slave
    typedef enum logic [1:0] {
        IR_OCIMEM    = 2'd0,
        IR_TRACECTRL = 2'd1,
        IR_BREAK     = 2'd2,
        IR_TRACEMEM  = 2'd3
    } ir_code_e;

    function automatic int action_bit(input int sr_w);
        return sr_w - 1;
    endfunction

    // Wide enough for IR widths up to 8; callers truncate to 2**IR_W bits
    function automatic logic [255:0] onehot(input logic [7:0] idx);
        return 256'(1) << idx;
    endfunction

endpackage

// File: rtl/nios_dbg_toggle_sync.sv
// Multi-flop synchroniser for the TCK-domain update toggle, with edge detect.
module nios_dbg_toggle_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_tgl,
    output logic o_event
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // Loading from the live input during reset means no event fires afterwards
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= {SYNC_STAGES{i_tgl}};
            r_prev <= i_tgl;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_tgl};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_event = r_sync[SYNC_STAGES-1] ^ r_prev;

endmodule

// File: rtl/nios_dbg_cmd_sysclk.sv
// System-clock side of the debug slave: toggle sync, command FIFO, strobe decode.
// Optional macro NIOS_DBG_CMD_PARITY_EN adds jtag_par / parity_err checking.
module nios_dbg_cmd_sysclk
    import nios_dbg_pkg::*;
#(
    parameter int IR_W        = IR_W_DEF,
    parameter int SR_W        = SR_W_DEF,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      jtag_upd_tgl,
    input  logic [IR_W-1:0]           jtag_ir,
    input  logic [SR_W-1:0]           jtag_sr,
`ifdef NIOS_DBG_CMD_PARITY_EN
    input  logic                      jtag_par,
    output logic                      parity_err,
`endif
    input  logic                      cmd_ready,
    output logic                      cmd_valid,
    output logic [IR_W-1:0]           cmd_ir,
    output logic [SR_W-1:0]           jdo,
    output logic [(2**IR_W)-1:0]      take_action,
    output logic [(2**IR_W)-1:0]      take_no_action,
    output logic                      overflow,
    input  logic                      overflow_clr,
    output logic [$clog2(DEPTH):0]    fifo_level
);

    localparam int NIR  = 2 ** IR_W;
    localparam int AW   = $clog2(DEPTH);
    localparam int LW   = AW + 1;
    localparam int EW   = IR_W + SR_W;
    localparam int ABIT = action_bit(SR_W);

    logic          w_event;
    logic          w_push_req;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic [EW-1:0] w_head;
    logic [NIR-1:0] w_dec;

    logic [EW-1:0]  r_mem [DEPTH];
    logic [AW-1:0]  r_wptr;
    logic [AW-1:0]  r_rptr;
    logic [LW-1:0]  r_level;
    logic           r_overflow;
    logic [NIR-1:0] r_take_action;
    logic [NIR-1:0] r_take_no_action;

    nios_dbg_toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk     (clk),
        .reset   (reset),
        .i_tgl   (jtag_upd_tgl),
        .o_event (w_event)
    );

`ifdef NIOS_DBG_CMD_PARITY_EN
    logic w_par_ok;
    logic r_parity_err;

    assign w_par_ok   = ^{jtag_par, jtag_ir, jtag_sr};
    assign w_push_req = w_event & w_par_ok;

    always_ff @(posedge clk) begin
        if (reset)
            r_parity_err <= 1'b0;
        else if (w_event && !w_par_ok)
            r_parity_err <= 1'b1;
        else if (overflow_clr)
            r_parity_err <= 1'b0;
    end

    assign parity_err = r_parity_err;
`else
    assign w_push_req = w_event;
`endif

    assign w_full = (r_level == LW'(DEPTH));
    assign w_pop  = (r_level != '0) & cmd_ready;
    // A push into a full FIFO is still accepted when the head leaves the same cycle
    assign w_push = w_push_req & (~w_full | w_pop);
    assign w_head = r_mem[r_rptr];
    assign w_dec  = NIR'(onehot(8'(w_head[EW-1:SR_W])));

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wptr] <= {jtag_ir, jtag_sr};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr           <= '0;
            r_rptr           <= '0;
            r_level          <= '0;
            r_overflow       <= 1'b0;
            r_take_action    <= '0;
            r_take_no_action <= '0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + 1'b1;
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
            if (w_push && !w_pop)
                r_level <= r_level + 1'b1;
            else if (!w_push && w_pop)
                r_level <= r_level - 1'b1;

            if (w_push_req && !w_push)
                r_overflow <= 1'b1;
            else if (overflow_clr)
                r_overflow <= 1'b0;

            r_take_action    <= (w_pop &&  w_head[ABIT]) ? w_dec : '0;
            r_take_no_action <= (w_pop && !w_head[ABIT]) ? w_dec : '0;
        end
    end

    assign cmd_valid      = (r_level != '0);
    assign cmd_ir         = cmd_valid ? w_head[EW-1:SR_W] : '0;
    assign jdo            = cmd_valid ? w_head[SR_W-1:0]  : '0;
    assign take_action    = r_take_action;
    assign take_no_action = r_take_no_action;
    assign overflow       = r_overflow;
    assign fifo_level     = r_level;

endmodule
